// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the d_mem arbiter: FSM encoding and requester port indices.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StRdata  = 2'd2
    } arb_state_e;

    localparam logic PortCpu = 1'b0;
    localparam logic PortDbg = 1'b1;

endpackage

// File: rtl/dmem_arb_starve_guard.sv
// Starvation guard for the debug port: counts consecutive CPU grants taken while the
// debug port was waiting and forces the next arbitration to the debug port at the limit.
// Only instantiated when DMEM_ARB_STARVE_GUARD_EN is defined.
module dmem_arb_starve_guard #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic idle_i,
    input  logic req1_i,
    input  logic gnt_cpu_i,
    input  logic gnt_dbg_i,
    output logic force_dbg_o
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign force_dbg_o = (cnt_q == CntW'(STARVE_LIMIT));

    // Clear when the debug port is served or has stopped asking; count CPU wins it sat through.
    always_comb begin
        cnt_d = cnt_q;
        if (idle_i && (gnt_dbg_i || !req1_i)) begin
            cnt_d = '0;
        end else if (gnt_cpu_i && req1_i && !force_dbg_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter state.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data BRAM. Port 0 is the CPU, port 1 the
// debug/host path. One access at a time: write takes a 2-cycle slot, read a 3-cycle slot
// ending in an rvalid pulse that hides the BRAM's 1-cycle read latency.
// Optional: DMEM_ARB_STARVE_GUARD_EN adds a starvation guard for the debug port.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_din_o,
    input  logic [DATA_W-1:0] mem_dout_i
);

    if (STARVE_LIMIT == 0) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT must be at least 1");
    end

    arb_state_e        state_q;
    logic              port_q;
    logic              we_q;
    logic              gnt0_q, gnt1_q, rvalid0_q, rvalid1_q, mem_we_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q, mem_din_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic              force_dbg;
    logic              win_dbg;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic arb_fire;

    assign arb_fire = (state_q == StIdle) && (req0_i || req1_i);

    dmem_arb_starve_guard #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_guard (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .idle_i      (state_q == StIdle),
        .req1_i      (req1_i),
        .gnt_cpu_i   (arb_fire && !win_dbg),
        .gnt_dbg_i   (arb_fire && win_dbg),
        .force_dbg_o (force_dbg)
    );
`else
    assign force_dbg = 1'b0;
`endif

    // Fixed priority to the CPU unless the guard is forcing the waiting debug port through.
    always_comb begin
        win_dbg   = !req0_i || (force_dbg && req1_i);
        win_we    = win_dbg ? we1_i    : we0_i;
        win_addr  = win_dbg ? addr1_i  : addr0_i;
        win_wdata = win_dbg ? wdata1_i : wdata0_i;
    end

    // Access sequencer with registered handshake and BRAM pin outputs.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            port_q     <= PortCpu;
            we_q       <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            mem_we_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req0_i || req1_i) begin
                        port_q     <= win_dbg ? PortDbg : PortCpu;
                        we_q       <= win_we;
                        mem_we_q   <= win_we;
                        mem_addr_q <= win_addr;
                        mem_din_q  <= win_wdata;
                        gnt0_q     <= !win_dbg;
                        gnt1_q     <= win_dbg;
                        state_q    <= StAccess;
                    end
                end
                // BRAM samples the pins at this edge; a write is already done.
                StAccess: begin
                    state_q <= we_q ? StIdle : StRdata;
                end
                StRdata: begin
                    if (port_q == PortCpu) begin
                        rdata0_q  <= mem_dout_i;
                        rvalid0_q <= 1'b1;
                    end else begin
                        rdata1_q  <= mem_dout_i;
                        rvalid1_q <= 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign gnt0_o     = gnt0_q;
    assign gnt1_o     = gnt1_q;
    assign rvalid0_o  = rvalid0_q;
    assign rvalid1_o  = rvalid1_q;
    assign rdata0_o   = rdata0_q;
    assign rdata1_o   = rdata1_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_din_o  = mem_din_q;

endmodule
